// File: rtl/timer.sv
// On-delay (TON) timer: hit_target asserts once `in` has been high for
// `target` consecutive rising edges; any low on `in` restarts the timing.
module timer #(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             in,
  output logic             hit_target
);

  logic [WIDTH-1:0] count;
  logic             elapsed;

  // Compares against the live target. Lowering target below count is
  // therefore seen at once, and a raised target resumes from count.
  assign elapsed = (count >= target);

  // NOTE: sequential state uses non-blocking assignments, so every
  // always_ff reads the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!in) begin
      count <= '0;
    end else if (!elapsed) begin
      count <= count + 1'b1;
    end
    // Once elapsed, count holds. The increment only happens while
    // count < target, so count can never wrap, even at target = 2^WIDTH-1.
  end

  // Combinational from the live `in`. The permissive therefore drops in the
  // same cycle `in` falls. With target = 0 this is a pure pass-through, and
  // that holds during reset as well.
  assign hit_target = in & elapsed;

endmodule

// File: tb/tb_timer.sv
// Directed-vector bench for timer (WIDTH=4): a per-edge table of inputs and
// expected count/hit_target, plus hand-written combinational corner cases.
module tb_timer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] target;
  logic             in;
  logic             hit_target;

  int checks = 0;
  int errors = 0;

  timer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .target    (target),
    .in        (in),
    .hit_target(hit_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             reset;
    logic             in;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] exp_count;
    logic             exp_hit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void add(input logic r, input logic i,
                              input logic [WIDTH-1:0] t,
                              input logic [WIDTH-1:0] c, input logic h);
    vecs.push_back('{reset: r, in: i, target: t, exp_count: c, exp_hit: h});
  endfunction

  // Apply inputs away from the edge, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic i, input logic [WIDTH-1:0] t);
    @(negedge clk);
    reset  = r;
    in     = i;
    target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    in     = 1'b0;
    target = 4'd8;

    // Reset, then hold low.
    add(1, 0, 8, 0, 0);
    for (int k = 0; k < 20; k++) add(0, 0, 8, 0, 0);
    // Basic delay: hit after exactly 8 high edges, then saturate.
    for (int k = 1; k <= 8; k++) add(0, 1, 8, 4'(k), k == 8);
    for (int k = 0; k < 20; k++) add(0, 1, 8, 8, 1);
    // Drop and re-raise: 8 edges needed again.
    add(0, 0, 8, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 8, 4'(k), k == 8);
    // Glitch: 5 high, 1 low, then a full 8 from the re-rise.
    add(0, 0, 8, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 1, 8, 4'(k), 0);
    add(0, 0, 8, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 8, 4'(k), k == 8);
    // target = 15: assert after 15 edges, then hold without wrapping.
    add(0, 0, 15, 0, 0);
    for (int k = 1; k <= 15; k++) add(0, 1, 15, 4'(k), k == 15);
    for (int k = 0; k < 3; k++) add(0, 1, 15, 15, 1);
    // Lower target 8 -> 3 at count=5: immediate assert, count holds.
    add(0, 0, 8, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 1, 8, 4'(k), 0);
    add(0, 1, 3, 5, 1);
    add(0, 1, 3, 5, 1);
    // Raise back to 8: counting resumes from 5.
    add(0, 1, 8, 6, 0);
    add(0, 1, 8, 7, 0);
    add(0, 1, 8, 8, 1);
    // Reset mid-count at count=6, then 8 more edges after release.
    add(0, 0, 8, 0, 0);
    for (int k = 1; k <= 6; k++) add(0, 1, 8, 4'(k), 0);
    add(1, 1, 8, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 8, 4'(k), k == 8);
    // target = 0: pass-through with count idle at 0.
    add(0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1);

    foreach (vecs[n]) begin
      step(vecs[n].reset, vecs[n].in, vecs[n].target);
      check($sformatf("vec%0d hit", n), 32'(hit_target), 32'(vecs[n].exp_hit));
      check($sformatf("vec%0d count", n), 32'(dut.count), 32'(vecs[n].exp_count));
    end

    // Same-cycle drop: reach the elapsed state, then drop `in` mid-cycle.
    step(1, 0, 8);
    for (int k = 0; k < 8; k++) step(0, 1, 8);
    check("pre_drop hit", 32'(hit_target), 32'd1);
    @(negedge clk);
    in = 1'b0;
    #1;
    check("drop same-cycle hit", 32'(hit_target), 32'd0);
    check("drop count held", 32'(dut.count), 32'd8);
    @(posedge clk);
    #1;
    check("drop count cleared", 32'(dut.count), 32'd0);

    // Lowering target mid-cycle asserts before any edge.
    step(0, 1, 8);
    step(0, 1, 8);
    step(0, 1, 8);
    @(negedge clk);
    target = 4'd2;
    #1;
    check("lower target comb hit", 32'(hit_target), 32'd1);

    // target = 0 passes `in` through combinationally, even while in reset.
    @(negedge clk);
    reset  = 1'b1;
    target = 4'd0;
    in     = 1'b1;
    #1;
    check("t0 reset in=1", 32'(hit_target), 32'd1);
    @(posedge clk);
    #1;
    check("t0 reset after edge", 32'(hit_target), 32'd1);
    in = 1'b0;
    #1;
    check("t0 reset in=0", 32'(hit_target), 32'd0);
    in = 1'b1;
    #1;
    check("t0 reset in=1 again", 32'(hit_target), 32'd1);
    // With a nonzero target, reset keeps hit_target low.
    target = 4'd8;
    #1;
    check("t8 reset hit", 32'(hit_target), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
